bsg_manycore_mesh_edge_responder: RTL and testbench



---
 rtl/bsg_manycore_pkg.sv | 69 ++++++
 rtl/bsg_two_fifo.sv | 62 ++++++
 rtl/bsg_manycore_mesh_edge_responder.sv | 128 ++++++++++++
 tb/tb_bsg_manycore_mesh_edge_responder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_manycore_pkg.sv
// Shared manycore packet definitions: op/return-type enums, struct-declaring
// macros and the link-width helper, plus constants used by the edge responder.
`ifndef BSG_MANYCORE_PKG_SV
`define BSG_MANYCORE_PKG_SV

`define BSG_MANYCORE_PACKET_WIDTH(a,d,x,y) ((a)+4+5+(d)+((d)/8)+2*(x)+2*(y))
`define BSG_MANYCORE_RETURN_PACKET_WIDTH(d,x,y) (2+(d)+5+(x)+(y))
`define BSG_MANYCORE_LINK_SIF_WIDTH(a,d,x,y) (`BSG_MANYCORE_PACKET_WIDTH(a,d,x,y)+`BSG_MANYCORE_RETURN_PACKET_WIDTH(d,x,y)+4)

`define DECLARE_BSG_MANYCORE_LINK_SIF_S(a,d,x,y) \
  typedef struct packed { \
    logic [(a)-1:0] addr; \
    bsg_manycore_packet_op_e op; \
    logic [bsg_manycore_reg_id_width_gp-1:0] reg_id; \
    logic [(d)-1:0] payload; \
    logic [((d)/8)-1:0] mask; \
    logic [(y)-1:0] src_y_cord; \
    logic [(x)-1:0] src_x_cord; \
    logic [(y)-1:0] y_cord; \
    logic [(x)-1:0] x_cord; \
  } bsg_manycore_packet_s; \
  typedef struct packed { \
    bsg_manycore_return_packet_type_e pkt_type; \
    logic [(d)-1:0] data; \
    logic [bsg_manycore_reg_id_width_gp-1:0] reg_id; \
    logic [(y)-1:0] y_cord; \
    logic [(x)-1:0] x_cord; \
  } bsg_manycore_return_packet_s; \
  typedef struct packed { \
    logic v; \
    bsg_manycore_packet_s data; \
    logic ready_and_rev; \
  } bsg_manycore_fwd_link_sif_s; \
  typedef struct packed { \
    logic v; \
    bsg_manycore_return_packet_s data; \
    logic ready_and_rev; \
  } bsg_manycore_rev_link_sif_s; \
  typedef struct packed { \
    bsg_manycore_fwd_link_sif_s fwd; \
    bsg_manycore_rev_link_sif_s rev; \
  } bsg_manycore_link_sif_s

package bsg_manycore_pkg;

  localparam int bsg_manycore_reg_id_width_gp = 5;
  localparam int csr_els_gp                   = 4;
  localparam int err_count_width_gp           = 16;

  typedef enum logic [3:0] {
    e_remote_load    = 4'd0,
    e_remote_store   = 4'd1,
    e_remote_sw      = 4'd2,
    e_remote_amoswap = 4'd3,
    e_remote_amoadd  = 4'd4,
    e_remote_amoor   = 4'd5,
    e_cache_op       = 4'd6
  } bsg_manycore_packet_op_e;

  typedef enum logic [1:0] {
    e_return_credit   = 2'd0,
    e_return_int_wb   = 2'd1,
    e_return_float_wb = 2'd2,
    e_return_ifetch   = 2'd3
  } bsg_manycore_return_packet_type_e;

endpackage

`endif

// File: rtl/bsg_two_fifo.sv
// Two-entry ready/valid FIFO with yumi-style dequeue; accepts a new entry every
// cycle while draining, and enqueue-to-valid latency of one cycle.
module bsg_two_fifo #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [1:0][width_p-1:0] mem_q;
  logic head_q, head_d, tail_q, tail_d;
  logic empty_q, empty_d, full_q, full_d;
  logic enq, deq;

  assign enq = v_i & ~full_q;
  assign deq = yumi_i & ~empty_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    empty_d = empty_q;
    full_d  = full_q;
    if (enq) tail_d = ~tail_q;
    if (deq) head_d = ~head_q;
    if (enq && !deq) begin
      empty_d = 1'b0;
      full_d  = (tail_d == head_q);
    end else if (deq && !enq) begin
      full_d  = 1'b0;
      empty_d = (head_d == tail_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[tail_q] <= data_i;
  end

  assign ready_o = ~full_q;
  assign v_o     = ~empty_q;
  assign data_o  = mem_q[head_q];

endmodule

// File: rtl/bsg_manycore_mesh_edge_responder.sv
// Mesh edge endpoint: answers every tile request leaving the array from a 4-word
// CSR window. Optional trace: define BSG_MANYCORE_MESH_EDGE_RESPONDER_TRACE_EN.
module bsg_manycore_mesh_edge_responder
  import bsg_manycore_pkg::*;
#(
  parameter int addr_width_p = 0,
  parameter int data_width_p = 32,
  parameter int x_cord_width_p = 0,
  parameter int y_cord_width_p = 0,
  parameter logic [data_width_p-1:0] csr_init_p = '0,
  localparam int link_sif_width_lp =
    `BSG_MANYCORE_LINK_SIF_WIDTH(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [link_sif_width_lp-1:0]  link_sif_i,
  output logic [link_sif_width_lp-1:0]  link_sif_o,
  input  logic [x_cord_width_p-1:0]     my_x_i,
  input  logic [y_cord_width_p-1:0]     my_y_i,
  output logic [err_count_width_gp-1:0] err_count_o
);

  `DECLARE_BSG_MANYCORE_LINK_SIF_S(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p);

  localparam int bytes_lp = data_width_p / 8;

  bsg_manycore_link_sif_s      link_in, link_out;
  bsg_manycore_packet_s        req;
  bsg_manycore_return_packet_s ret, fifo_data;

  logic fifo_ready, fifo_v, fwd_ready, accept, rev_v, rsp_yumi;
  logic addr_ok, is_load, is_store, unsupported;
  logic [1:0] idx;
  logic [bytes_lp-1:0] wmask;

  logic [csr_els_gp-1:0][data_width_p-1:0] csr_q, csr_d;
  logic [err_count_width_gp-1:0] err_q, err_d;

  assign link_in = link_sif_i;
  assign req     = link_in.fwd.data;

  // Ready is held low through reset so nothing is accepted into a flushing FIFO.
  assign fwd_ready = fifo_ready & ~reset_i;
  assign accept    = link_in.fwd.v & fwd_ready;

  assign idx         = req.addr[1:0];
  assign addr_ok     = (req.addr[addr_width_p-1:2] == '0);
  assign is_load     = addr_ok & (req.op == e_remote_load);
  assign is_store    = addr_ok & ((req.op == e_remote_store) | (req.op == e_remote_sw));
  assign unsupported = ~(is_load | is_store);
  assign wmask       = (req.op == e_remote_sw) ? '1 : req.mask;

  always_comb begin
    csr_d = csr_q;
    if (accept && is_store) begin
      for (int b = 0; b < bytes_lp; b++) begin
        if (wmask[b]) csr_d[idx][8*b +: 8] = req.payload[8*b +: 8];
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if (accept && unsupported && (err_q != '1)) err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      csr_q <= {csr_els_gp{csr_init_p}};
      err_q <= '0;
    end else begin
      csr_q <= csr_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    ret          = '0;
    ret.pkt_type = is_load ? e_return_int_wb : e_return_credit;
    ret.data     = is_load ? csr_q[idx] : '0;
    ret.reg_id   = req.reg_id;
    ret.y_cord   = req.src_y_cord;
    ret.x_cord   = req.src_x_cord;
  end

  bsg_two_fifo #(
    .width_p($bits(bsg_manycore_return_packet_s))
  ) rsp_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .ready_o (fifo_ready),
    .data_i  (ret),
    .v_i     (accept),
    .v_o     (fifo_v),
    .data_o  (fifo_data),
    .yumi_i  (rsp_yumi)
  );

  assign rev_v    = fifo_v & ~reset_i;
  assign rsp_yumi = rev_v & link_in.rev.ready_and_rev;

  always_comb begin
    link_out                   = '0;
    link_out.fwd.ready_and_rev = fwd_ready;
    link_out.rev.v             = rev_v;
    link_out.rev.data          = fifo_data;
  end

  assign link_sif_o  = link_out;
  assign err_count_o = err_q;

  logic unused_bits;
  assign unused_bits = ^{link_in.fwd.ready_and_rev, link_in.rev.v, link_in.rev.data,
                         req.x_cord, req.y_cord, my_x_i, my_y_i};

`ifdef BSG_MANYCORE_MESH_EDGE_RESPONDER_TRACE_EN
  always_ff @(posedge clk_i) begin
    if (!reset_i && accept) begin
      $display("[%0t] edge(%0d,%0d) op=%0d addr=%h data=%h src=(%0d,%0d)",
               $time, my_x_i, my_y_i, req.op, req.addr, req.payload,
               req.src_x_cord, req.src_y_cord);
      if (unsupported) $warning("edge(%0d,%0d) unsupported op=%0d addr=%h",
                                my_x_i, my_y_i, req.op, req.addr);
    end
  end
`endif

endmodule

// File: tb/tb_bsg_manycore_mesh_edge_responder.sv
// Scoreboard bench for the mesh edge responder: a CSR/error model predicts every
// return packet at accept time; responses are popped and compared in order.
module tb_bsg_manycore_mesh_edge_responder;
  import bsg_manycore_pkg::*;

  localparam int A = 12;
  localparam int D = 32;
  localparam int X = 4;
  localparam int Y = 4;
  localparam logic [D-1:0] INIT = 32'hC0FFEE00;
  localparam int LW = `BSG_MANYCORE_LINK_SIF_WIDTH(A, D, X, Y);

  `DECLARE_BSG_MANYCORE_LINK_SIF_S(A, D, X, Y);

  logic clk = 1'b0;
  logic reset;
  bsg_manycore_link_sif_s li, lo;
  logic [LW-1:0] lo_flat;
  logic [15:0] err_count;
  logic [X-1:0] my_x = 4'd2;
  logic [Y-1:0] my_y = 4'd0;

  bsg_manycore_mesh_edge_responder #(
    .addr_width_p   (A),
    .data_width_p   (D),
    .x_cord_width_p (X),
    .y_cord_width_p (Y),
    .csr_init_p     (INIT)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .link_sif_i  (li),
    .link_sif_o  (lo_flat),
    .my_x_i      (my_x),
    .my_y_i      (my_y),
    .err_count_o (err_count)
  );

  assign lo = lo_flat;

  logic fwd_ready, rev_v;
  bsg_manycore_return_packet_s rev_pkt;
  assign fwd_ready = lo.fwd.ready_and_rev;
  assign rev_v     = lo.rev.v;
  assign rev_pkt   = lo.rev.data;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cnt  = 0;

  bsg_manycore_return_packet_s exp_q[$];
  bsg_manycore_return_packet_s rsp_log[$];
  logic [D-1:0] m_csr [4];
  logic [15:0]  m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 50) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_csr[i] = INIT;
    m_err = 16'd0;
    exp_q.delete();
  endtask

  function automatic bsg_manycore_packet_s mk(input bsg_manycore_packet_op_e op,
      input logic [A-1:0] addr, input logic [D-1:0] data, input logic [D/8-1:0] mask,
      input logic [4:0] rid, input logic [X-1:0] sx, input logic [Y-1:0] sy);
    mk            = '0;
    mk.op         = op;
    mk.addr       = addr;
    mk.payload    = data;
    mk.mask       = mask;
    mk.reg_id     = rid;
    mk.src_x_cord = sx;
    mk.src_y_cord = sy;
  endfunction

  always @(posedge clk) cyc++;

  // Pop before push: a response leaving now always belongs to an older request.
  always @(negedge clk) begin
    if (!reset && rev_v && li.rev.ready_and_rev) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 64'(1), 64'(0));
      else chk("rsp_pkt", 64'(rev_pkt), 64'(exp_q.pop_front()));
      rsp_log.push_back(rev_pkt);
    end
    if (!reset && li.fwd.v && fwd_ready) begin
      bsg_manycore_packet_s p;
      bsg_manycore_return_packet_s e;
      p = li.fwd.data;
      e = '0;
      e.pkt_type = e_return_credit;
      e.reg_id   = p.reg_id;
      e.x_cord   = p.src_x_cord;
      e.y_cord   = p.src_y_cord;
      if (p.addr[A-1:2] != '0 ||
          !(p.op == e_remote_load || p.op == e_remote_store || p.op == e_remote_sw)) begin
        if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
      end else if (p.op == e_remote_load) begin
        e.pkt_type = e_return_int_wb;
        e.data     = m_csr[p.addr[1:0]];
      end else begin
        for (int b = 0; b < D/8; b++)
          if (p.op == e_remote_sw || p.mask[b])
            m_csr[p.addr[1:0]][8*b +: 8] = p.payload[8*b +: 8];
      end
      exp_q.push_back(e);
      acc_cnt++;
    end
  end

  task automatic send(input bsg_manycore_packet_s p);
    bit done;
    done = 1'b0;
    li.fwd.v    = 1'b1;
    li.fwd.data = p;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      done = fwd_ready;
      @(posedge clk);
      #1;
    end
    if (!done) chk("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic idle(input int n);
    li.fwd.v = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_q", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, rsp0, c0;
    reset = 1'b1;
    li    = '0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_fwd_ready", 64'(fwd_ready), 64'(0));
    chk("rst_rev_v", 64'(rev_v), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_fwd_ready", 64'(fwd_ready), 64'(1));
    chk("post_rst_rev_v", 64'(rev_v), 64'(0));
    chk("post_rst_err", 64'(err_count), 64'(0));
    @(posedge clk);
    #1;

    // sw then load, same index, from (3,5)
    li.rev.ready_and_rev = 1'b1;
    rsp_log.delete();
    send(mk(e_remote_sw, 12'd2, 32'hDEADBEEF, 4'h0, 5'd7, 4'd3, 4'd5));
    chk("latency_rev_v", 64'(rev_v), 64'(1));
    send(mk(e_remote_load, 12'd2, 32'h0, 4'h0, 5'd9, 4'd3, 4'd5));
    idle(1);
    drain();
    chk("b_rsp_count", 64'(rsp_log.size()), 64'(2));
    chk("sw_type", 64'(rsp_log[0].pkt_type), 64'(e_return_credit));
    chk("sw_x", 64'(rsp_log[0].x_cord), 64'(3));
    chk("sw_y", 64'(rsp_log[0].y_cord), 64'(5));
    chk("sw_data", 64'(rsp_log[0].data), 64'(0));
    chk("ld_type", 64'(rsp_log[1].pkt_type), 64'(e_return_int_wb));
    chk("ld_data", 64'(rsp_log[1].data), 64'(32'hDEADBEEF));
    chk("ld_reg_id", 64'(rsp_log[1].reg_id), 64'(9));

    // Byte-masked store and back-to-back store/load
    rsp_log.delete();
    send(mk(e_remote_store, 12'd1, 32'h11223344, 4'hF, 5'd1, 4'd1, 4'd1));
    send(mk(e_remote_store, 12'd1, 32'h0000AB00, 4'b0010, 5'd2, 4'd1, 4'd1));
    send(mk(e_remote_load, 12'd1, 32'h0, 4'h0, 5'd4, 4'd1, 4'd1));
    send(mk(e_remote_sw, 12'd3, 32'hA5A50F0F, 4'h0, 5'd5, 4'd6, 4'd2));
    send(mk(e_remote_load, 12'd3, 32'h0, 4'h0, 5'd6, 4'd6, 4'd2));
    idle(1);
    drain();
    chk("mask_load", 64'(rsp_log[2].data), 64'(32'h1122AB44));
    chk("raw_load", 64'(rsp_log[4].data), 64'(32'hA5A50F0F));
    chk("raw_type", 64'(rsp_log[4].pkt_type), 64'(e_return_int_wb));

    // Out-of-window address is unsupported
    rsp_log.delete();
    send(mk(e_remote_sw, 12'h010, 32'h12345678, 4'h0, 5'd3, 4'd0, 4'd7));
    send(mk(e_remote_load, 12'd0, 32'h0, 4'h0, 5'd8, 4'd0, 4'd7));
    idle(1);
    drain();
    chk("badaddr_err", 64'(err_count), 64'(1));
    chk("badaddr_type", 64'(rsp_log[0].pkt_type), 64'(e_return_credit));
    chk("badaddr_csr0", 64'(rsp_log[1].data), 64'(INIT));

    // Backpressure: only two accepted while the return path is stalled
    rsp_log.delete();
    li.rev.ready_and_rev = 1'b0;
    acc0 = acc_cnt;
    fork
      begin
        for (int k = 0; k < 5; k++)
          send(mk(e_remote_load, A'(k % 4), 32'h0, 4'h0, 5'(10 + k), 4'd4, 4'd4));
        li.fwd.v = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #2;
        chk("bp_accepted", 64'(acc_cnt - acc0), 64'(2));
        chk("bp_fwd_ready", 64'(fwd_ready), 64'(0));
        li.rev.ready_and_rev = 1'b1;
      end
    join
    idle(2);
    drain();
    chk("bp_total", 64'(acc_cnt - acc0), 64'(5));
    chk("bp_rsp_count", 64'(rsp_log.size()), 64'(5));
    for (int k = 0; k < 5; k++) chk("bp_order", 64'(rsp_log[k].reg_id), 64'(10 + k));

    // Error counter saturation with sustained one-per-cycle throughput
    rsp0 = rsp_log.size();
    send(mk(e_remote_amoswap, 12'd0, 32'h1, 4'h0, 5'd0, 4'd2, 4'd2));
    c0 = cyc;
    for (int k = 0; k < 65536; k++)
      send(mk((k % 2 == 0) ? e_remote_amoadd : e_cache_op, A'(k % 4), 32'h0, 4'h0,
              5'(k), 4'd2, 4'd2));
    chk("throughput", 64'(cyc - c0), 64'(65536));
    idle(2);
    drain();
    chk("err_saturated", 64'(err_count), 64'(16'hFFFF));
    chk("sat_rsp_count", 64'(rsp_log.size() - rsp0), 64'(65537));
    rsp_log.delete();

    // Reset with responses queued
    li.rev.ready_and_rev = 1'b0;
    send(mk(e_remote_load, 12'd2, 32'h0, 4'h0, 5'd1, 4'd1, 4'd1));
    send(mk(e_remote_load, 12'd3, 32'h0, 4'h0, 5'd2, 4'd1, 4'd1));
    li.fwd.v = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      chk("midrst_rev_v", 64'(rev_v), 64'(0));
      chk("midrst_fwd_ready", 64'(fwd_ready), 64'(0));
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    @(negedge clk);
    chk("after_rst_fwd_ready", 64'(fwd_ready), 64'(1));
    chk("after_rst_err", 64'(err_count), 64'(0));
    repeat (3) begin
      chk("after_rst_rev_v", 64'(rev_v), 64'(0));
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    li.rev.ready_and_rev = 1'b1;
    rsp_log.delete();
    send(mk(e_remote_load, 12'd0, 32'h0, 4'h0, 5'd3, 4'd1, 4'd1));
    send(mk(e_remote_load, 12'd2, 32'h0, 4'h0, 5'd4, 4'd1, 4'd1));
    idle(1);
    drain();
    chk("rst_rsp_count", 64'(rsp_log.size()), 64'(2));
    chk("rst_csr0", 64'(rsp_log[0].data), 64'(INIT));
    chk("rst_csr2", 64'(rsp_log[1].data), 64'(INIT));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
